led_display_arbiter: RTL and testbench
======================================

# led_display_arbiter

Shares the four-digit seven-segment display between two requesters, e.g. register-file readout and ALU result. The block owns the refresh prescaler, the digit-scan sequencer and a frame-synchronous round-robin arbiter. It drives the one-cold anode lines and the 4-bit hex nibble to the existing seven-segment decoder. Ownership changes, and snapshots of the displayed value, happen only at frame boundaries, so the display never tears.

## Interface
- REFRESH_DIV, 50000: clk cycles per digit slot; legal range ≥ 2.
- HOLD_FRAMES, 256: full scan frames an owner keeps the display while the other side is waiting; legal range ≥ 1.
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  2  display requests; bit0 = requester 0, bit1 = requester 1; level-sensitive.
- data0  in  16  value from requester 0; four hex digits, digit0 = [3:0].
- data1  in  16  value from requester 1.
- gnt  out  2  one-hot grant or 2'b00; registered.
- an  out  4  anodes, active-low, at most one low; an[0] = rightmost digit.
- seg_sel  out  2  index of the digit currently scanned; registered.
- hex_digit  out  4  nibble of the snapshot selected by seg_sel; 4'h0 when idle.
- frame_done  out  1  one-cycle pulse on the first cycle of each new frame.

## Operation
- Prescaler pre_cnt counts 0..REFRESH_DIV-1 and wraps. `tick` = (pre_cnt == REFRESH_DIV-1).
- On tick, seg_sel advances 0→1→2→3→0.
- Frame boundary = tick while seg_sel == 3.
- Scanning runs continuously, including when idle.
- States are IDLE, OWN0 and OWN1. There is also a last_owner bit (reset = 1, so requester 0 wins the first contention) and hold_cnt, which saturates at HOLD_FRAMES-1.
- Decisions are taken only at a frame boundary:
  - IDLE: if both requests are set, grant the requester opposite last_owner; if one is set, grant it; if none, stay IDLE.
  - OWNx, req[x] low: go to OWN(other) if the other requests, else IDLE.
  - OWNx, req[x] high, other requesting, hold_cnt == HOLD_FRAMES-1: go to OWN(other).
  - OWNx otherwise: stay and increment hold_cnt.
  - Every ownership change clears hold_cnt and updates last_owner.
- Snapshot: at every boundary, snap ← data of the next owner. When the next state is IDLE, snap ← 16'h0000.
- Requests or data changes mid-frame are ignored until the next boundary. An owner that drops req mid-frame keeps gnt until the boundary.
- Outputs:
  - an = one-cold decode of seg_sel while owned; 4'b1111 while IDLE.
  - hex_digit = snap[4*seg_sel +: 4].
  - an and hex_digit are decoded from registers only, with no input-to-output path.

## Timing
- Reset values: gnt = 00, an = 1111, seg_sel = 0, hex_digit = 0, frame_done = 0, pre_cnt = 0, state = IDLE, hold_cnt = 0.
- Reset asserted mid-frame forces the reset values immediately. Scanning restarts from seg_sel = 0 with a full slot of REFRESH_DIV cycles.
- seg_sel changes on the edge where tick is high, so each slot is exactly REFRESH_DIV cycles and each frame is exactly 4·REFRESH_DIV cycles.
- gnt, snap and seg_sel = 0 update on the same edge. frame_done is high for the following cycle only.
- Grant latency from req assertion is between 1 and 4·REFRESH_DIV cycles.
- Worst-case wait under contention is HOLD_FRAMES frames plus one frame.
- A request pulse that falls entirely between two boundaries is lost by design.

## Configuration
- DISP_LZ_BLANK_EN defined: leading-zero blanking.
  - For slots above the most significant nonzero nibble of snap, an stays 1111.
  - Digit 0 is always lit while owned, so 16'h0000 shows a single "0".
- DISP_LZ_BLANK_EN undefined: all four digits are lit while owned.

## Test plan
All scenarios use REFRESH_DIV = 4 and HOLD_FRAMES = 2.
1. Hold reset_n low, then release, with no requests → an = 1111 and gnt = 00 throughout; seg_sel steps every 4 cycles; frame_done pulses every 16 cycles.
2. req = 01 and data0 = 16'h1234 asserted mid-frame → gnt = 01 at the next boundary; slots show an = 1110/4, 1101/3, 1011/2, 0111/1.
3. req = 11, data0 = 16'h1234, data1 = 16'hABCD from IDLE → gnt = 01 for 2 frames, then 10 for 2 frames, alternating; hex_digit follows the owner.
4. Owner 0 with data0 changed to 16'h5678 at seg_sel = 1 → digits still show 1234 until the boundary, then 5678.
5. req[0] dropped mid-frame with req[1] = 0 → gnt stays 01 until the boundary, then 00 and an = 1111; reset_n pulsed mid-frame returns all outputs to their reset values immediately.
6. With DISP_LZ_BLANK_EN defined and data0 = 16'h0042 → slots 3 and 2 give an = 1111; slots 1 and 0 light with 4 and 2; data0 = 16'h0000 lights slot 0 only.

Source files
------------

// File: rtl/led_display_arbiter.sv
// Two-requester owner of a 4-digit seven-segment display: prescaler, digit scan, frame-synchronous round-robin arbiter.
// Latency: grant/snapshot change only on a frame boundary (1..4*REFRESH_DIV cycles after req); an/hex_digit come from registers only.
// Backpressure: none; req is level-sensitive, a waiting requester gets the display after at most HOLD_FRAMES+1 frames.
// Optional feature: define DISP_LZ_BLANK_EN for leading-zero blanking.
module led_display_arbiter #(
    parameter int REFRESH_DIV = 50000,
    parameter int HOLD_FRAMES = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic [1:0]  gnt,
    output logic [3:0]  an,
    output logic [1:0]  seg_sel,
    output logic [3:0]  hex_digit,
    output logic        frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   pre_cnt;
    logic [HW-1:0]   hold_cnt, hold_nx;
    logic            last_owner, last_nx;
    logic [15:0]     snap, snap_nx;
    logic            tick;
    logic            boundary;

    assign tick     = (pre_cnt == PRE_LAST);
    assign boundary = tick && (seg_sel == 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            seg_sel <= 2'd0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
            if (tick) begin
                seg_sel <= seg_sel + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            last_owner <= 1'b1;
            snap       <= 16'h0000;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            hold_cnt   <= hold_nx;
            last_owner <= last_nx;
            snap       <= snap_nx;
            frame_done <= boundary;
        end
    end

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        last_nx  = last_owner;
        snap_nx  = snap;
        if (boundary) begin
            case (state)
                IDLE: begin
                    if (req == 2'b11)  state_nx = last_owner ? OWN0 : OWN1;
                    else if (req[0])   state_nx = OWN0;
                    else if (req[1])   state_nx = OWN1;
                end
                OWN0: begin
                    if (!req[0])                              state_nx = req[1] ? OWN1 : IDLE;
                    else if (req[1] && hold_cnt == HOLD_LAST) state_nx = OWN1;
                end
                OWN1: begin
                    if (!req[1])                              state_nx = req[0] ? OWN0 : IDLE;
                    else if (req[0] && hold_cnt == HOLD_LAST) state_nx = OWN0;
                end
                default: state_nx = IDLE;
            endcase

            // Any state change restarts the hold window; IDLE keeps the previous owner for fairness.
            if (state_nx != state) begin
                hold_nx = '0;
                if (state_nx == OWN0)      last_nx = 1'b0;
                else if (state_nx == OWN1) last_nx = 1'b1;
            end else if (state != IDLE && hold_cnt != HOLD_LAST) begin
                hold_nx = hold_cnt + HW'(1);
            end

            case (state_nx)
                OWN0:    snap_nx = data0;
                OWN1:    snap_nx = data1;
                default: snap_nx = 16'h0000;
            endcase
        end
    end

    logic lit;

`ifdef DISP_LZ_BLANK_EN
    logic [1:0] msd;

    always_comb begin
        msd = 2'd0;
        if (snap[7:4]   != 4'h0) msd = 2'd1;
        if (snap[11:8]  != 4'h0) msd = 2'd2;
        if (snap[15:12] != 4'h0) msd = 2'd3;
        lit = (seg_sel <= msd);
    end
`else
    assign lit = 1'b1;
`endif

    always_comb begin
        gnt       = {state == OWN1, state == OWN0};
        hex_digit = snap[{seg_sel, 2'b00} +: 4];
        an        = 4'b1111;
        if (state != IDLE && lit) begin
            an[seg_sel] = 1'b0;
        end
    end

endmodule

// File: tb/tb_led_display_arbiter.sv
// Directed bench for led_display_arbiter with REFRESH_DIV=4, HOLD_FRAMES=2 (16-cycle frames).
module tb_led_display_arbiter;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req;
    logic [15:0] data0;
    logic [15:0] data1;
    logic [1:0]  gnt;
    logic [3:0]  an;
    logic [1:0]  seg_sel;
    logic [3:0]  hex_digit;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    logic lz;

    led_display_arbiter #(.REFRESH_DIV(4), .HOLD_FRAMES(2)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .data0(data0), .data1(data1),
        .gnt(gnt), .an(an), .seg_sel(seg_sel), .hex_digit(hex_digit), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [1:0] exp_sel;
        logic       exp_fd;
        reset_n = 1'b0; req = 2'b00; data0 = 16'h0; data1 = 16'h0;
        #12;
        checks++;
        if ({gnt, an, seg_sel, hex_digit, frame_done} !== {2'b00, 4'b1111, 2'd0, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_vals: gnt=%b an=%b sel=%0d hex=%h fd=%b", gnt, an, seg_sel, hex_digit, frame_done);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            exp_sel = 2'((k / 4) % 4);
            exp_fd  = (k % 16 == 0);
            checks++;
            if (seg_sel !== exp_sel || frame_done !== exp_fd || an !== 4'b1111 || gnt !== 2'b00) begin
                errors++;
                $display("FAIL idle_scan k=%0d: sel=%0d fd=%b an=%b gnt=%b, want sel=%0d fd=%b an=1111 gnt=00",
                         k, seg_sel, frame_done, an, gnt, exp_sel, exp_fd);
            end
        end
    endtask

    task automatic test_single;
        bit ok;
        logic [15:0] v;
        logic [3:0]  oc;
        wait_frame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_sync: no frame_done within 100 cycles"); end
        step(5);
        req = 2'b01; data0 = 16'h1234; v = 16'h1234;
        checks++;
        if (gnt !== 2'b00) begin errors++; $display("FAIL single_early: gnt=%b want 00", gnt); end
        step(10);
        checks++;
        if (gnt !== 2'b00 || an !== 4'b1111) begin
            errors++; $display("FAIL single_preboundary: gnt=%b an=%b want 00/1111", gnt, an);
        end
        step(1);
        checks++;
        if (gnt !== 2'b01 || frame_done !== 1'b1) begin
            errors++; $display("FAIL single_grant: gnt=%b fd=%b want 01/1", gnt, frame_done);
        end
        for (int s = 0; s < 4; s++) begin
            oc = 4'b1111; oc[s] = 1'b0;
            checks++;
            if (an !== oc || hex_digit !== v[4*s +: 4]) begin
                errors++;
                $display("FAIL single_slot%0d: an=%b hex=%h want %b/%h", s, an, hex_digit, oc, v[4*s +: 4]);
            end
            step(4);
        end
    endtask

    task automatic test_data_change;
        bit ok;
        wait_frame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL chg_sync: no frame_done within 100 cycles"); end
        step(4);
        data0 = 16'h5678;
        checks++;
        if (hex_digit !== 4'h3) begin errors++; $display("FAIL chg_slot1: hex=%h want 3", hex_digit); end
        step(4);
        checks++;
        if (hex_digit !== 4'h2) begin errors++; $display("FAIL chg_slot2: hex=%h want 2", hex_digit); end
        step(4);
        checks++;
        if (hex_digit !== 4'h1) begin errors++; $display("FAIL chg_slot3: hex=%h want 1", hex_digit); end
        step(4);
        checks++;
        if (frame_done !== 1'b1 || hex_digit !== 4'h8 || gnt !== 2'b01) begin
            errors++; $display("FAIL chg_new0: fd=%b hex=%h gnt=%b want 1/8/01", frame_done, hex_digit, gnt);
        end
        step(4);
        checks++;
        if (hex_digit !== 4'h7) begin errors++; $display("FAIL chg_new1: hex=%h want 7", hex_digit); end
    endtask

    task automatic test_drop;
        bit ok;
        wait_frame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL drop_sync: no frame_done within 100 cycles"); end
        step(6);
        req = 2'b00;
        checks++;
        if (gnt !== 2'b01 || an !== 4'b1101) begin
            errors++; $display("FAIL drop_hold: gnt=%b an=%b want 01/1101", gnt, an);
        end
        step(9);
        checks++;
        if (gnt !== 2'b01 || an !== 4'b0111) begin
            errors++; $display("FAIL drop_last: gnt=%b an=%b want 01/0111", gnt, an);
        end
        step(1);
        checks++;
        if (gnt !== 2'b00 || an !== 4'b1111 || hex_digit !== 4'h0 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL drop_idle: gnt=%b an=%b hex=%h fd=%b want 00/1111/0/1", gnt, an, hex_digit, frame_done);
        end
    endtask

    task automatic test_reset_midframe;
        bit ok;
        req = 2'b01; data0 = 16'h1234;
        wait_frame(ok);
        checks++;
        if (!ok || gnt !== 2'b01) begin errors++; $display("FAIL rst_pre: ok=%b gnt=%b want 1/01", ok, gnt); end
        step(6);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({gnt, an, seg_sel, hex_digit, frame_done} !== {2'b00, 4'b1111, 2'd0, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL rst_async: gnt=%b an=%b sel=%0d hex=%h fd=%b", gnt, an, seg_sel, hex_digit, frame_done);
        end
        req = 2'b00;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step(3);
        checks++;
        if (seg_sel !== 2'd0) begin errors++; $display("FAIL rst_slot_len: sel=%0d want 0", seg_sel); end
        step(1);
        checks++;
        if (seg_sel !== 2'd1 || an !== 4'b1111) begin
            errors++; $display("FAIL rst_advance: sel=%0d an=%b want 1/1111", seg_sel, an);
        end
    endtask

    task automatic test_contention;
        bit ok;
        req = 2'b11; data0 = 16'h1234; data1 = 16'hABCD;
        wait_frame(ok);
        checks++;
        if (!ok || gnt !== 2'b01 || hex_digit !== 4'h4) begin
            errors++; $display("FAIL cont_f1: ok=%b gnt=%b hex=%h want 1/01/4", ok, gnt, hex_digit);
        end
        step(12);
        checks++;
        if (hex_digit !== 4'h1) begin errors++; $display("FAIL cont_f1_slot3: hex=%h want 1", hex_digit); end
        wait_frame(ok);
        checks++;
        if (!ok || gnt !== 2'b01) begin errors++; $display("FAIL cont_f2: ok=%b gnt=%b want 1/01", ok, gnt); end
        wait_frame(ok);
        checks++;
        if (!ok || gnt !== 2'b10 || hex_digit !== 4'hD) begin
            errors++; $display("FAIL cont_f3: ok=%b gnt=%b hex=%h want 1/10/d", ok, gnt, hex_digit);
        end
        step(12);
        checks++;
        if (hex_digit !== 4'hA || an !== 4'b0111) begin
            errors++; $display("FAIL cont_f3_slot3: hex=%h an=%b want a/0111", hex_digit, an);
        end
        wait_frame(ok);
        checks++;
        if (!ok || gnt !== 2'b10) begin errors++; $display("FAIL cont_f4: ok=%b gnt=%b want 1/10", ok, gnt); end
        wait_frame(ok);
        checks++;
        if (!ok || gnt !== 2'b01) begin errors++; $display("FAIL cont_f5: ok=%b gnt=%b want 1/01", ok, gnt); end
    endtask

    task automatic test_digits;
        bit ok;
        logic [15:0] v;
        logic [3:0]  oc, mask, exp_an;
        for (int p = 0; p < 2; p++) begin
            v = (p == 0) ? 16'h0042 : 16'h0000;
            mask = lz ? ((p == 0) ? 4'b0011 : 4'b0001) : 4'b1111;
            req = 2'b01; data0 = v;
            wait_frame(ok);
            checks++;
            if (!ok || gnt !== 2'b01) begin errors++; $display("FAIL dig%0d_sync: ok=%b gnt=%b", p, ok, gnt); end
            for (int s = 0; s < 4; s++) begin
                oc = 4'b1111; oc[s] = 1'b0;
                exp_an = mask[s] ? oc : 4'b1111;
                checks++;
                if (an !== exp_an || hex_digit !== v[4*s +: 4]) begin
                    errors++;
                    $display("FAIL dig%0d_slot%0d: an=%b hex=%h want %b/%h", p, s, an, hex_digit, exp_an, v[4*s +: 4]);
                end
                step(4);
            end
        end
        req = 2'b00;
    endtask

    initial begin
`ifdef DISP_LZ_BLANK_EN
        lz = 1'b1;
`else
        lz = 1'b0;
`endif
        test_reset();
        test_single();
        test_data_change();
        test_drop();
        test_reset_midframe();
        test_contention();
        test_digits();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
